// File: rtl/display_7segmentos.sv
// display_7segmentos: scans a sign-magnitude BCD result across an 8-digit common-anode display (clk, reset, codigo_BCD[20:0] in; anodo[7:0], catodo[6:0] active-low out)
module display_7segmentos #(
  parameter int REFRESH_COUNT = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [20:0] codigo_BCD,
  output logic [7:0]  anodo,
  output logic [6:0]  catodo
);
  localparam int PW = (REFRESH_COUNT > 2) ? $clog2(REFRESH_COUNT) : 1;
  localparam logic [6:0] SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
  };
  logic [PW-1:0] prescaler;
  logic [2:0]    index;
  logic [31:0]   ext;
  logic [3:0]    digit;
  logic [7:0]    nz;
  logic [6:0]    pattern;
  assign ext   = {11'b0, codigo_BCD};
  assign digit = ext[{index, 2'b00} +: 4];
  always_comb begin
    nz = '0;
    nz[4] = |ext[19:16];
    for (int i = 3; i >= 0; i--) nz[i] = nz[i+1] | (|ext[i*4 +: 4]);
  end
  // nz[k] marks a non-zero digit at or above position k, so leading zeros blank while inner zeros stay lit
  assign pattern = (index < 3'd5) ? ((index != 3'd0 && !nz[index]) ? 7'h7F : SEG[digit]) :
                   (index == 3'd5 && ext[20]) ? 7'h3F : 7'h7F;
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
      index     <= '0;
      anodo     <= 8'hFF;
      catodo    <= 7'h7F;
    end else begin
      prescaler <= (prescaler == PW'(REFRESH_COUNT - 1)) ? '0 : prescaler + 1'b1;
      index     <= (prescaler == PW'(REFRESH_COUNT - 1)) ? index + 3'd1 : index;
      anodo     <= ~(8'b1 << index);
      catodo    <= pattern;
    end
  end
endmodule

// File: tb/tb_display_7segmentos.sv
// tb_display_7segmentos: directed-vector self-checking bench for display_7segmentos
module tb_display_7segmentos;
  logic        clk = 1'b0;
  logic        reset;
  logic [20:0] codigo_BCD;
  logic [7:0]  anodo;
  logic [6:0]  catodo;
  int n_checks = 0;
  int n_fail = 0;
  display_7segmentos #(.REFRESH_COUNT(4)) dut (
    .clk(clk), .reset(reset), .codigo_BCD(codigo_BCD), .anodo(anodo), .catodo(catodo)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic run(input string tag, input logic [6:0] e [8], input int npos);
    for (int p = 0; p < npos; p++)
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        check($sformatf("%s_an%0d_%0d", tag, p, c), anodo, ~(8'b1 << p));
        check($sformatf("%s_cat%0d_%0d", tag, p, c), {1'b0, catodo}, {1'b0, e[p]});
      end
  endtask
  task automatic hold_reset(input string tag, input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check($sformatf("%s_an%0d", tag, i), anodo, 8'hFF);
      check($sformatf("%s_cat%0d", tag, i), {1'b0, catodo}, 8'h7F);
    end
    reset = 1'b0;
  endtask
  logic [6:0] e28  [8] = '{7'h00, 7'h24, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
  logic [6:0] eneg [8] = '{7'h19, 7'h00, 7'h30, 7'h02, 7'h79, 7'h3F, 7'h7F, 7'h7F};
  logic [6:0] ezer [8] = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
  logic [6:0] einv [8] = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
  logic [6:0] e105 [8] = '{7'h12, 7'h40, 7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
  logic [6:0] enz  [8] = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h7F, 7'h7F};
  logic [6:0] einh [8] = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h7F, 7'h3F, 7'h7F, 7'h7F};
  initial begin
    codigo_BCD = 21'h000028;
    hold_reset("rst", 3);
    run("p28", e28, 8);
    codigo_BCD = 21'h116384;
    run("neg", eneg, 8);
    codigo_BCD = 21'h000000;
    run("zero", ezer, 8);
    run("zero2", ezer, 1);
    run("zero2", ezer, 0);
    codigo_BCD = 21'h00000C;
    hold_reset("rst2", 1);
    run("inv", einv, 8);
    codigo_BCD = 21'h000105;
    run("p105", e105, 8);
    codigo_BCD = 21'h100000;
    run("negz", enz, 8);
    codigo_BCD = 21'h1A0000;
    run("invhi", einh, 8);
    codigo_BCD = 21'h116384;
    run("pre", eneg, 5);
    hold_reset("mid", 2);
    run("post", eneg, 8);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
